// File: rtl/vmicro16_apb_pkg.sv
// Shared constants for the APB master bridge: state encoding, default bus width,
// abort read value and timeout counter width.
package vmicro16_apb_pkg;
  localparam int APB_BUS_WIDTH = 16;

  localparam logic [1:0] APB_IDLE   = 2'd0;
  localparam logic [1:0] APB_SETUP  = 2'd1;
  localparam logic [1:0] APB_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = APB_IDLE,
    ST_SETUP  = APB_SETUP,
    ST_ACCESS = APB_ACCESS
  } apb_state_e;

  // Aborted reads return all-ones; replicated to the instance's bus width.
  localparam logic APB_ABORT_BIT = 1'b1;

  // Covers TIMEOUT_CYCLES up to 255.
  localparam int APB_TO_W = 8;
endpackage

// File: rtl/apb_master_bridge.sv
// Single-beat core request -> APB master (IDLE/SETUP/ACCESS) with registered M_* outputs.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import vmicro16_apb_pkg::*;
#(
  parameter int BUS_WIDTH      = APB_BUS_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 S_PCLK,
  input  logic                 S_PRESETn,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [BUS_WIDTH-1:0] core_addr,
  input  logic [BUS_WIDTH-1:0] core_wdata,
  output logic [BUS_WIDTH-1:0] core_rdata,
  output logic                 core_ack,
  output logic                 core_err,
  output logic                 core_busy,
  output logic [BUS_WIDTH-1:0] M_PADDR,
  output logic                 M_PWRITE,
  output logic                 M_PSELx,
  output logic                 M_PENABLE,
  output logic [BUS_WIDTH-1:0] M_PWDATA,
  input  logic [BUS_WIDTH-1:0] M_PRDATA,
  input  logic                 M_PREADY
);

  apb_state_e state, state_nxt;
  logic       done, abort;

`ifdef APB_TIMEOUT_EN
  localparam logic [APB_TO_W-1:0] TO_LAST = APB_TO_W'(TIMEOUT_CYCLES - 1);
  logic [APB_TO_W-1:0] to_cnt;
`endif

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE:   if (core_req) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        // Ready on the limit cycle still completes normally.
        if (M_PREADY) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
`endif
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_PCLK or negedge S_PRESETn) begin
    if (!S_PRESETn) begin
      state      <= ST_IDLE;
      M_PSELx    <= 1'b0;
      M_PENABLE  <= 1'b0;
      M_PADDR    <= '0;
      M_PWRITE   <= 1'b0;
      M_PWDATA   <= '0;
      core_rdata <= '0;
      core_ack   <= 1'b0;
    end else begin
      state     <= state_nxt;
      M_PSELx   <= (state_nxt != ST_IDLE);
      M_PENABLE <= (state_nxt == ST_ACCESS);
      core_ack  <= done | abort;
      if (state == ST_IDLE && core_req) begin
        M_PADDR  <= core_addr;
        M_PWRITE <= core_we;
        M_PWDATA <= core_wdata;
      end
      if (done && !M_PWRITE)
        core_rdata <= M_PRDATA;
      else if (abort && !M_PWRITE)
        core_rdata <= {BUS_WIDTH{APB_ABORT_BIT}};
    end
  end

  assign core_busy = (state != ST_IDLE);

`ifdef APB_TIMEOUT_EN
  // Counts stalled ACCESS cycles; restarted whenever a new transfer is accepted.
  always_ff @(posedge S_PCLK or negedge S_PRESETn) begin
    if (!S_PRESETn) begin
      to_cnt   <= '0;
      core_err <= 1'b0;
    end else begin
      core_err <= abort;
      if (state == ST_IDLE && core_req)
        to_cnt <= '0;
      else if (state == ST_ACCESS && !M_PREADY)
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign core_err       = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; the timeout section follows APB_TIMEOUT_EN.
module tb_apb_master_bridge;
  localparam int W = 16;

  logic         S_PCLK = 1'b0;
  logic         S_PRESETn;
  logic         core_req, core_we;
  logic [W-1:0] core_addr, core_wdata, core_rdata;
  logic         core_ack, core_err, core_busy;
  logic [W-1:0] M_PADDR, M_PWDATA, M_PRDATA;
  logic         M_PWRITE, M_PSELx, M_PENABLE, M_PREADY;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;
  int ack_base;
  logic saw_ack, saw_err;

  always #5 S_PCLK = ~S_PCLK;

  always @(negedge S_PCLK) if (core_ack === 1'b1) ack_cnt++;

`ifdef APB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  apb_master_bridge #(.BUS_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .S_PCLK(S_PCLK), .S_PRESETn(S_PRESETn),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack), .core_err(core_err), .core_busy(core_busy),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge S_PCLK);
      #1;
    end
  endtask

  // psel, penable, busy, ack, err packed for compact checks
  function automatic logic [31:0] ctl();
    return {27'd0, M_PSELx, M_PENABLE, core_busy, core_ack, core_err};
  endfunction

  task automatic issue(input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
  endtask

  initial begin
    S_PRESETn = 1'b0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    M_PRDATA = 16'hDEAD; M_PREADY = 1'b1;
    #2;
    chk("reset_ctl", ctl(), 32'h0);
    chk("reset_paddr", {16'd0, M_PADDR}, 32'h0);
    chk("reset_pwdata", {16'd0, M_PWDATA}, 32'h0);
    chk("reset_rdata", {16'd0, core_rdata}, 32'h0);
    #10 S_PRESETn = 1'b1;
    tick();

    // zero-wait write
    issue(1'b1, 16'h0084, 16'hBEEF);
    tick(); core_req = 0; core_addr = 16'h1111; core_wdata = 16'h2222;
    chk("wr_c1_ctl", ctl(), 32'b10100);
    chk("wr_c1_addr", {M_PWRITE, M_PADDR, M_PWDATA}, {15'd0, 1'b1, 16'h0084, 16'hBEEF} >> 0);
    tick();
    chk("wr_c2_ctl", ctl(), 32'b11100);
    chk("wr_c2_addr", {16'd0, M_PADDR}, 32'h0084);
    tick();
    chk("wr_c3_ctl", ctl(), 32'b00010);
    chk("wr_c3_rdata", {16'd0, core_rdata}, 32'h0);
    tick();
    chk("wr_c4_ctl", ctl(), 32'b00000);
    chk("wr_c4_hold", {16'd0, M_PADDR}, 32'h0084);

    // wait-state read: three stalled ACCESS cycles, data ignored until ready
    M_PREADY = 1'b0; M_PRDATA = 16'hDEAD;
    issue(1'b0, 16'h0092, 16'h5555);
    tick(); core_req = 0;
    chk("rd_c1_ctl", ctl(), 32'b10100);
    tick();
    chk("rd_c2_ctl", ctl(), 32'b11100);
    tick();
    chk("rd_c3_ctl", ctl(), 32'b11100);
    chk("rd_c3_frozen", {M_PWRITE, M_PADDR}, {15'd0, 1'b0, 16'h0092});
    tick();
    chk("rd_c4_ctl", ctl(), 32'b11100);
    tick(); M_PREADY = 1'b1; M_PRDATA = 16'h1234;
    chk("rd_c5_ctl", ctl(), 32'b11100);
    tick(); M_PRDATA = 16'hDEAD;
    chk("rd_c6_ctl", ctl(), 32'b00010);
    chk("rd_c6_rdata", {16'd0, core_rdata}, 32'h1234);
    tick();
    chk("rd_c7_hold", {16'd0, core_rdata}, 32'h1234);
    chk("rd_c7_ctl", ctl(), 32'b00000);

    // back-to-back reads with req held; pulse during busy ignored
    ack_base = ack_cnt;
    issue(1'b0, 16'h00A0, 16'h0);
    tick(); core_addr = 16'h00B4;
    chk("b2b_c1_addr", {16'd0, M_PADDR}, 32'h00A0);
    M_PRDATA = 16'h1111;
    tick();
    chk("b2b_c2_ctl", ctl(), 32'b11100);
    tick(); M_PRDATA = 16'h2222;
    chk("b2b_c3_ctl", ctl(), 32'b00010);
    chk("b2b_c3_rdata", {16'd0, core_rdata}, 32'h1111);
    tick(); core_req = 1'b1;
    chk("b2b_c4_ctl", ctl(), 32'b10100);
    chk("b2b_c4_addr", {16'd0, M_PADDR}, 32'h00B4);
    tick(); core_req = 1'b0;
    chk("b2b_c5_ctl", ctl(), 32'b11100);
    tick();
    chk("b2b_c6_ctl", ctl(), 32'b00010);
    chk("b2b_c6_rdata", {16'd0, core_rdata}, 32'h2222);
    tick(3);
    chk("b2b_idle_ctl", ctl(), 32'b00000);
    chk("b2b_ack_count", ack_cnt - ack_base, 32'd2);

    // asynchronous reset during a waited read
    M_PREADY = 1'b0;
    issue(1'b0, 16'h00C0, 16'h0);
    tick(); core_req = 0;
    tick();
    chk("rst_pre_ctl", ctl(), 32'b11100);
    #2 S_PRESETn = 1'b0;
    #1;
    chk("rst_mid_ctl", ctl(), 32'b00000);
    chk("rst_mid_addr", {16'd0, M_PADDR}, 32'h0);
    chk("rst_mid_rdata", {16'd0, core_rdata}, 32'h0);
    #3 S_PRESETn = 1'b1; M_PREADY = 1'b1;
    ack_base = ack_cnt;
    tick(4);
    chk("rst_no_ack", ack_cnt - ack_base, 32'd0);
    M_PRDATA = 16'h7777;
    issue(1'b0, 16'h00C4, 16'h0);
    tick(); core_req = 0;
    tick(2);
    chk("rst_next_ctl", ctl(), 32'b00010);
    chk("rst_next_rdata", {16'd0, core_rdata}, 32'h7777);

    // write leaves core_rdata untouched
    M_PRDATA = 16'hAAAA;
    issue(1'b1, 16'h00D0, 16'h1357);
    tick(); core_req = 0;
    chk("wr2_pwdata", {16'd0, M_PWDATA}, 32'h1357);
    tick(2);
    chk("wr2_ctl", ctl(), 32'b00010);
    chk("wr2_rdata_hold", {16'd0, core_rdata}, 32'h7777);
    tick();

`ifdef APB_TIMEOUT_EN
    // stuck ready: abort after 4 ACCESS cycles with all-ones data
    M_PREADY = 1'b0;
    issue(1'b0, 16'h00E0, 16'h0);
    tick(); core_req = 0;
    tick(4);
    chk("to_c5_ctl", ctl(), 32'b11100);
    tick();
    chk("to_c6_ctl", ctl(), 32'b00011);
    chk("to_c6_rdata", {16'd0, core_rdata}, 32'hFFFF);
    tick();
    chk("to_c7_ctl", ctl(), 32'b00000);
    // ready on the limit cycle wins
    issue(1'b0, 16'h00E4, 16'h0);
    tick(); core_req = 0;
    tick(4); M_PREADY = 1'b1; M_PRDATA = 16'h2468;
    chk("tolim_c5_ctl", ctl(), 32'b11100);
    tick();
    chk("tolim_c6_ctl", ctl(), 32'b00010);
    chk("tolim_c6_rdata", {16'd0, core_rdata}, 32'h2468);
`else
    // without the timeout, a stuck ready waits indefinitely
    M_PREADY = 1'b0;
    saw_ack = 1'b0; saw_err = 1'b0;
    issue(1'b0, 16'h00E0, 16'h0);
    tick(); core_req = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      saw_ack |= (core_ack !== 1'b0);
      saw_err |= (core_err !== 1'b0);
    end
    chk("stuck_no_ack", {31'd0, saw_ack}, 32'd0);
    chk("stuck_no_err", {31'd0, saw_err}, 32'd0);
    chk("stuck_ctl", ctl(), 32'b11100);
    M_PREADY = 1'b1; M_PRDATA = 16'h3C3C;
    tick();
    chk("stuck_done_ctl", ctl(), 32'b00010);
    chk("stuck_done_rdata", {16'd0, core_rdata}, 32'h3C3C);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts single-beat core/MMU load-store requests into APB transfers.
- Drives the interconnect's slave-side APB port, which decodes the address into per-peripheral selects.
- Owns the APB master FSM (IDLE/SETUP/ACCESS), holds address and data stable across wait states, and returns read data with a one-cycle completion pulse.

Parameters:
- BUS_WIDTH, 16, width of address and data buses.
- TIMEOUT_CYCLES, 255, ACCESS-phase cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- S_PCLK  input  1  single clock for the core side and the APB side.
- S_PRESETn  input  1  asynchronous, active-low reset.
- core_req  input  1  request strobe; sampled only in IDLE.
- core_we  input  1  1 = write, 0 = read.
- core_addr  input  BUS_WIDTH  unfiltered MMU address.
- core_wdata  input  BUS_WIDTH  write data.
- core_rdata  output  BUS_WIDTH  read data; valid when core_ack=1, held until the next read completes.
- core_ack  output  1  one-cycle completion pulse.
- core_err  output  1  qualifies core_ack; 1 = transfer aborted.
- core_busy  output  1  high whenever FSM is not IDLE.
- M_PADDR  output  BUS_WIDTH  APB address.
- M_PWRITE  output  1  APB direction.
- M_PSELx  output  1  APB select toward the interconnect.
- M_PENABLE  output  1  APB enable.
- M_PWDATA  output  BUS_WIDTH  APB write data.
- M_PRDATA  input  BUS_WIDTH  APB read data from the interconnect.
- M_PREADY  input  1  APB ready from the interconnect.

Behaviour:
- Reset (asynchronous, active-low): FSM=IDLE; all outputs 0 immediately, including M_PADDR/M_PWDATA/core_rdata. Reset mid-transfer drops PSEL/PENABLE at once; no ack is issued for the killed transfer.
- Address, direction and data are registered. Every M_* output is a flop, with no combinational path from core_* inputs.
- IDLE: PSEL=0, PENABLE=0; M_PADDR/M_PWRITE/M_PWDATA hold their last values.
  - On core_req=1: latch addr/we/wdata into M_PADDR/M_PWRITE/M_PWDATA; go to SETUP.
  - M_PWDATA is latched for reads too; its value is don't-care on reads.
- SETUP: PSEL=1, PENABLE=0, for exactly one cycle; then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. M_PREADY is sampled at each rising edge.
  - On ready: for a read, core_rdata<=M_PRDATA; core_ack=1 in the following cycle; FSM -> IDLE; PSEL/PENABLE low in that same cycle.
  - PREADY=0: stay in ACCESS with all M_* outputs frozen; unlimited wait states.
- Latency: req sampled at edge 0 -> SETUP in cycle 1 -> ACCESS in cycle 2. With zero wait states, ack is high in cycle 3. Each wait state adds one cycle.
- Back-to-back: core_req high during the ack cycle is accepted, because the FSM is in IDLE. Minimum issue interval is 3 cycles. core_req while busy is ignored, not queued; the core must hold req or re-issue.
- Writes update core_rdata never; core_rdata keeps the last read value.
- M_PRDATA is ignored outside ACCESS; PREADY outside ACCESS is ignored.
- core_err=0 always unless the optional feature fires.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: an 8-bit counter (sized to TIMEOUT_CYCLES) clears on SETUP entry and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: PSEL/PENABLE drop next cycle, FSM -> IDLE, core_ack=1 with core_err=1.
  - On a read abort, core_rdata is set to all-ones.
  - PREADY arriving in the same cycle as the limit wins: normal completion, err=0.
- Undefined: no counter is synthesised; core_err is tied 0; ACCESS waits indefinitely.

Decomposition:
- Shared package vmicro16_apb_pkg holds:
  - state encoding constants APB_IDLE=2'd0, APB_SETUP=2'd1, APB_ACCESS=2'd2;
  - default BUS_WIDTH;
  - the abort read value (all-ones);
  - the timeout counter width.
- No sub-module: FSM, latches and counter are inline.

Test Plan:
- Zero-wait write: req, we=1, addr=16'h0084, wdata=16'hBEEF, PREADY=1 -> PSEL high cycles 1-2, PENABLE high cycle 2 only, PADDR/PWDATA stable, ack in cycle 3, err=0.
- Wait-state read: req read addr=16'h0092, PREADY low for 3 ACCESS cycles, PRDATA=16'h1234 on ready -> ack in cycle 6, core_rdata=16'h1234, all M_* frozen during waits.
- Back-to-back: req held high for two reads (16'h00A0, 16'h00B4) -> second SETUP in the cycle after first ack; req pulses during busy are ignored; exactly 2 acks.
- Reset mid-ACCESS: assert S_PRESETn=0 asynchronously between edges during a waited read -> PSEL/PENABLE/core_busy 0 immediately; no ack after release; next req completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4: read with PREADY stuck 0 -> ack with err=1 after 4 ACCESS cycles, core_rdata=16'hFFFF. Second case: PREADY=1 on the limit cycle -> err=0.
- Undefined macro: same stuck-PREADY stimulus for 1000 cycles -> remains in ACCESS, no ack, core_err constant 0.
